uart_program_loader: RTL and testbench

//  Serial boot loader that writes the 28-bit instruction store read by the MiniAlu fetch path.

---
 rtl/uart_program_loader_pkg.sv | 23 ++
 rtl/uart_program_loader_rx.sv | 108 ++++++++++
 rtl/uart_program_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_program_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte and state encodings
// for the frame FSM and the RX byte receiver.
package uart_program_loader_pkg;

  localparam logic [7:0] LDR_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } ldr_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchroniser, start-bit glitch rejection,
// centre sampling of data bits and a stop-bit framing check.
module uart_rx_byte
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iRx,
  output logic [7:0] oByte,
  output logic       oByteValid,
  output logic       oFrameErr,
  output rx_state_t  oState
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          full_hit, half_hit, fall_edge;

  assign full_hit  = (cnt_q == FULL_LAST);
  assign half_hit  = (cnt_q == HALF_LAST);
  assign fall_edge = rx_prev_q & ~rx_sync_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= R_IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= iRx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (fall_edge) state_d = R_START;
      R_START: if (half_hit) state_d = rx_sync_q ? R_IDLE : R_DATA;
      R_DATA:  if (full_hit && bit_q == 3'd7) state_d = R_STOP;
      R_STOP:  if (full_hit) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      R_IDLE: cnt_d = '0;
      R_START: begin
        if (half_hit) begin
          cnt_d = '0;
          bit_d = '0;
        end
      end
      R_DATA: begin
        if (full_hit) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      R_STOP: begin
        if (full_hit) begin
          cnt_d   = '0;
          valid_d = rx_sync_q;
          ferr_d  = ~rx_sync_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // oByteValid is a one-cycle pulse with oByte stable alongside it; there is no
  // ready, so the consumer must take every byte in the cycle it is offered.
  assign oByte      = shift_q;
  assign oByteValid = valid_q;
  assign oFrameErr  = ferr_q;
  assign oState     = state_q;

endmodule

// File: rtl/uart_program_loader.sv
// Serial boot loader: parses A5/N/words/CHK frames from the UART and writes the
// instruction store, holding the CPU in reset until a checksum-valid image lands.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_WIDTH   = 8,
  parameter int INSN_WIDTH   = 28
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iRx,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [INSN_WIDTH-1:0] oInstruction,
  output logic                  oCpuHold,
  output logic                  oLoadDone,
  output logic                  oError,
  output logic [2:0]            oDbgState,
  output logic [1:0]            oDbgRxState
);

  localparam int PW = INSN_WIDTH - 8;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;
  rx_state_t  rx_state;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .Clock      (Clock),
    .Reset      (Reset),
    .iRx        (iRx),
    .oByte      (rx_byte),
    .oByteValid (rx_valid),
    .oFrameErr  (rx_ferr),
    .oState     (rx_state)
  );

  ldr_state_t            state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, idx_inc;
  logic [1:0]            bpos_q, bpos_d;
  logic [PW-1:0]         pend_q, pend_d;
  logic [7:0]            acc_q, acc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic                  hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic                  last_word;

  assign idx_inc   = idx_q + ADDR_WIDTH'(1);
  assign last_word = (idx_inc == ADDR_WIDTH'(n_q));

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      bpos_q  <= '0;
      pend_q  <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      insn_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bpos_q  <= bpos_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      insn_q  <= insn_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // A framing error aborts from any state; otherwise only accepted bytes advance.
  always_comb begin
    state_d = state_q;
    if (rx_ferr) begin
      state_d = S_ERROR;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (rx_byte == LDR_SYNC) state_d = S_COUNT;
        S_COUNT: state_d = (rx_byte == 8'h00) ? S_ERROR : S_DATA;
        S_DATA: begin
          if (bpos_q == 2'd0 && rx_byte[7:4] != 4'h0) state_d = S_ERROR;
          else if (bpos_q == 2'd3 && last_word)      state_d = S_CHECK;
        end
        S_CHECK: state_d = (rx_byte == acc_q) ? S_DONE : S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    n_d    = n_q;
    idx_d  = idx_q;
    bpos_d = bpos_q;
    pend_d = pend_q;
    acc_d  = acc_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    insn_d = insn_q;
    hold_d = hold_q;
    done_d = done_q;
    err_d  = err_q;
    if (rx_valid) begin
      case (state_q)
        S_COUNT: begin
          n_d    = rx_byte;
          idx_d  = '0;
          acc_d  = rx_byte;
          bpos_d = '0;
        end
        S_DATA: begin
          acc_d  = acc_q ^ rx_byte;
          pend_d = {pend_q[PW-9:0], rx_byte};
          bpos_d = bpos_q + 2'd1;
          if (bpos_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = idx_q;
            insn_d = {pend_q, rx_byte};
            idx_d  = idx_inc;
          end
        end
        default: ;
      endcase
    end
    if (state_d == S_COUNT && state_q != S_COUNT) begin
      hold_d = 1'b1;
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (state_d == S_DONE && state_q == S_CHECK) begin
      hold_d = 1'b0;
      done_d = 1'b1;
    end
    if (state_d == S_ERROR) begin
      err_d  = 1'b1;
      hold_d = 1'b1;
      done_d = 1'b0;
    end
  end

  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oInstruction  = insn_q;
  assign oCpuHold      = hold_q;
  assign oLoadDone     = done_q;
  assign oError        = err_q;
  assign oDbgState     = state_q;
  assign oDbgRxState   = rx_state;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table-driven frames, hand-written corner
// sequences and randomized frames checked against a frame-level model.
module tb_uart_program_loader;
  import uart_program_loader_pkg::*;

  localparam int CPB      = 8;
  localparam int AW       = 8;
  localparam int IW       = 28;
  localparam int W        = AW + IW;
  localparam int BYTE_CYC = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          we;
  logic [AW-1:0] waddr;
  logic [IW-1:0] insn;
  logic          hold, done, err;
  logic [2:0]    dbg_state;
  logic [1:0]    dbg_rx;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW), .INSN_WIDTH(IW)) dut (
    .Clock         (clk),
    .Reset         (rst_n),
    .iRx           (rx),
    .oWriteEnable  (we),
    .oWriteAddress (waddr),
    .oInstruction  (insn),
    .oCpuHold      (hold),
    .oLoadDone     (done),
    .oError        (err),
    .oDbgState     (dbg_state),
    .oDbgRxState   (dbg_rx)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor
  logic [W-1:0] obs_q[$];
  int           obs_t[$];
  always @(negedge clk) begin
    if (we) begin
      obs_q.push_back({waddr, insn});
      obs_t.push_back(cyc);
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           obs_rd = 0;
  int           checks = 0;
  int           errors = 0;
  logic [27:0]  fw[0:255];

  typedef struct {
    int              n;
    logic [2:0][27:0] w;
    logic [7:0]      flip;
    logic            space;
    logic            e_done;
    logic            e_err;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // driver
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic logic [7:0] word_xor(input logic [27:0] w);
    return {4'h0, w[27:24]} ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic send_word(input logic [27:0] w);
    send_byte({4'h0, w[27:24]}, 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  // bad_word < 0: no format error; otherwise that word's first byte gets a nonzero upper nibble
  task automatic send_frame(input int n, input logic [7:0] chk_flip, input int bad_word);
    logic [7:0] chk;
    send_byte(LDR_SYNC, 1'b1);
    send_byte(8'(n), 1'b1);
    chk = 8'(n);
    for (int i = 0; i < n; i++) begin
      if (i == bad_word) begin
        send_byte({4'($urandom_range(1, 15)), fw[i][27:24]}, 1'b1);
        return;
      end
      send_word(fw[i]);
      chk = chk ^ word_xor(fw[i]);
    end
    send_byte(chk ^ chk_flip, 1'b1);
  endtask

  // reference model: a frame writes every word before the first bad one, in address order
  task automatic model_frame(input int n, input logic [7:0] chk_flip, input int bad_word,
                             output logic e_done, output logic e_err);
    int good;
    good = (bad_word >= 0 && bad_word < n) ? bad_word : n;
    for (int i = 0; i < good; i++) exp_q.push_back({AW'(i), fw[i]});
    e_err  = (bad_word >= 0) || (chk_flip != 8'h00);
    e_done = !e_err;
  endtask

  task automatic compare_writes(input string name);
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      check({name, " strobe"}, 64'(obs_q[obs_rd]), 64'(exp_q.pop_front()));
      obs_rd++;
    end
    check({name, " extra strobes"}, 64'(obs_q.size() - obs_rd), 64'd0);
    obs_rd = obs_q.size();
    check({name, " missing strobes"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_status(input string name, input logic e_done, input logic e_err);
    check({name, " done"}, 64'(done), 64'(e_done));
    check({name, " error"}, 64'(err), 64'(e_err));
    check({name, " hold"}, 64'(hold), 64'(!e_done));
    check({name, " we idle"}, 64'(we), 64'd0);
  endtask

  task automatic settle();
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic check_reset_values(input string name);
    check({name, " hold"}, 64'(hold), 64'd1);
    check({name, " we"}, 64'(we), 64'd0);
    check({name, " addr"}, 64'(waddr), 64'd0);
    check({name, " insn"}, 64'(insn), 64'd0);
    check({name, " done"}, 64'(done), 64'd0);
    check({name, " error"}, 64'(err), 64'd0);
    check({name, " state"}, 64'(dbg_state), 64'(S_IDLE));
    check({name, " rx state"}, 64'(dbg_rx), 64'(R_IDLE));
  endtask

  initial begin
    logic e_done, e_err;
    int   start, n, kind, bad;
    logic [7:0] flip, chk;

    tbl[0] = '{1, {28'h0, 28'h0, 28'h1123456}, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{3, {28'h0FEDCBA, 28'h7001234, 28'h2ABCDEF}, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1, {28'h0, 28'h0, 28'h1123456}, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{2, {28'h0, 28'h3000001, 28'hF0F0F0F}, 8'h00, 1'b0, 1'b1, 1'b0};

    // reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    settle();

    // table-driven frames
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < tbl[v].n; i++) fw[i] = tbl[v].w[i];
      start = obs_t.size();
      for (int i = 0; i < tbl[v].n; i++) exp_q.push_back({AW'(i), tbl[v].w[i]});
      send_frame(tbl[v].n, tbl[v].flip, -1);
      settle();
      if (tbl[v].space) begin
        check("spacing count", 64'(obs_t.size() - start), 64'd3);
        for (int k = start + 1; k < obs_t.size(); k++)
          check("strobe spacing", 64'(obs_t[k] - obs_t[k-1]), 64'(4 * BYTE_CYC));
      end
      compare_writes($sformatf("table%0d", v));
      check_status($sformatf("table%0d", v), tbl[v].e_done, tbl[v].e_err);
    end

    // N == 0, then recovery with a valid image
    send_byte(LDR_SYNC, 1'b1);
    send_byte(8'h00, 1'b1);
    settle();
    compare_writes("n0");
    check_status("n0", 1'b0, 1'b1);
    fw[0] = 28'h5A5A5A5;
    model_frame(1, 8'h00, -1, e_done, e_err);
    send_frame(1, 8'h00, -1);
    settle();
    compare_writes("n0 recover");
    check_status("n0 recover", e_done, e_err);

    // framing error during S_DATA
    fw[0] = 28'h8123456;
    exp_q.push_back({AW'(0), fw[0]});
    send_byte(LDR_SYNC, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(fw[0]);
    send_byte(8'h3C, 1'b0);
    settle();
    compare_writes("framing");
    check_status("framing", 1'b0, 1'b1);

    // a one-cycle glitch while waiting for N must not be taken as a byte
    fw[0] = 28'h0C0FFEE;
    exp_q.push_back({AW'(0), fw[0]});
    send_byte(LDR_SYNC, 1'b1);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (BYTE_CYC) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_word(fw[0]);
    chk = 8'h01 ^ word_xor(fw[0]);
    send_byte(chk, 1'b1);
    settle();
    compare_writes("glitch");
    check_status("glitch", 1'b1, 1'b0);

    // reset in the middle of word 2 of a 3-word load
    fw[0] = 28'h1111111;
    fw[1] = 28'h2222222;
    exp_q.push_back({AW'(0), fw[0]});
    send_byte(LDR_SYNC, 1'b1);
    send_byte(8'h03, 1'b1);
    send_word(fw[0]);
    send_byte({4'h0, fw[1][27:24]}, 1'b1);
    send_byte(fw[1][23:16], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid reset");
    rst_n = 1'b1;
    compare_writes("mid reset");
    fw[0] = 28'h9876543;
    model_frame(1, 8'h00, -1, e_done, e_err);
    send_frame(1, 8'h00, -1);
    settle();
    compare_writes("after reset");
    check_status("after reset", e_done, e_err);

    // randomized frames
    for (int r = 0; r < 12; r++) begin
      n    = $urandom_range(1, 5);
      kind = $urandom_range(0, 3);
      flip = 8'h00;
      bad  = -1;
      for (int i = 0; i < n; i++) fw[i] = 28'($urandom);
      if (kind == 2) flip = 8'($urandom_range(1, 255));
      if (kind == 3) bad = $urandom_range(0, n - 1);
      model_frame(n, flip, bad, e_done, e_err);
      send_frame(n, flip, bad);
      settle();
      compare_writes($sformatf("rand%0d", r));
      check_status($sformatf("rand%0d", r), e_done, e_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
